// File: rtl/sequence_detector_1011.sv
// Mealy FSM that flags each occurrence of the serial pattern 1-0-1-1 (oldest bit first).
// The flag is combinational from the current state and input, so it is valid in the cycle that holds the final '1'.
module sequence_detector_1011 #(
    parameter int OVERLAP = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic sequence_in,
    output logic detector_out
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        S1   = 2'b01,
        S10  = 2'b10,
        S101 = 2'b11
    } state_t;

    state_t r_state;
    state_t w_nextState;
    logic   w_match;

    // Synchronous active-low reset discards any partial prefix.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = IDLE;
        w_match     = 1'b0;
        case (r_state)
            IDLE: begin
                w_nextState = sequence_in ? S1 : IDLE;
            end
            S1: begin
                w_nextState = sequence_in ? S1 : S10;
            end
            S10: begin
                w_nextState = sequence_in ? S101 : IDLE;
            end
            S101: begin
                if (sequence_in) begin
                    w_match = 1'b1;
                    // The trailing '1' may seed the next match only when overlap is enabled.
                    w_nextState = (OVERLAP != 0) ? S1 : IDLE;
                end else begin
                    w_nextState = S10;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_match     = 1'b0;
            end
        endcase
    end

    assign detector_out = w_match & reset;

endmodule

// File: tb/tb_sequence_detector_1011.sv
// Directed self-checking bench for sequence_detector_1011; runs overlapping and non-overlapping instances side by side.
module tb_sequence_detector_1011;

    logic clock;
    logic reset;
    logic sequence_in;
    logic detOv;
    logic detNo;

    int checks;
    int errors;

    sequence_detector_1011 #(.OVERLAP(1)) dutOv (
        .clock        (clock),
        .reset        (reset),
        .sequence_in  (sequence_in),
        .detector_out (detOv)
    );

    sequence_detector_1011 #(.OVERLAP(0)) dutNo (
        .clock        (clock),
        .reset        (reset),
        .sequence_in  (sequence_in),
        .detector_out (detNo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one bit, sample both flags mid-cycle, then commit it on the next rising edge.
    task automatic stepBit(input logic b, output logic oOv, output logic oNo);
        sequence_in = b;
        @(negedge clock);
        oOv = detOv;
        oNo = detNo;
        @(posedge clock);
        #1;
    endtask

    task automatic applyReset();
        reset       = 1'b0;
        sequence_in = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic oOv, oNo;
        logic vOv, vNo;
        reset = 1'b1;
        stepBit(1'b1, oOv, oNo);
        stepBit(1'b0, oOv, oNo);
        stepBit(1'b1, oOv, oNo);
        // Both instances now sit in S101; a '1' under reset must not flag.
        reset       = 1'b0;
        sequence_in = 1'b1;
        #1;
        checks++;
        if (detOv !== 1'b0 || detNo !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_masks_s101: got ov=%b no=%b, want 0 0", detOv, detNo);
        end
        for (int i = 0; i < 3; i++) begin
            stepBit(i[0] ? 1'b0 : 1'b1, vOv, vNo);
            checks++;
            if (vOv !== 1'b0 || vNo !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_hold_%0d: got ov=%b no=%b, want 0 0", i, vOv, vNo);
            end
        end
        reset = 1'b1;
        sequence_in = 1'b0;
        checks++;
        if (dutOv.r_state !== 2'b00 || dutNo.r_state !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_state: got ov=%b no=%b, want 00 00", dutOv.r_state, dutNo.r_state);
        end
    endtask

    task automatic test_single_match();
        logic [4:0] pattern = 5'b01011;
        logic [4:0] expect1 = 5'b00001;
        logic oOv, oNo;
        applyReset();
        for (int i = 4; i >= 0; i--) begin
            stepBit(pattern[i], oOv, oNo);
            checks++;
            if (oOv !== expect1[i] || oNo !== expect1[i]) begin
                errors++;
                $display("[TB] FAIL single_bit%0d: got ov=%b no=%b, want %b", 5 - i, oOv, oNo, expect1[i]);
            end
        end
        checks++;
        if (dutOv.r_state !== 2'b01 || dutNo.r_state !== 2'b00) begin
            errors++;
            $display("[TB] FAIL single_state: got ov=%b no=%b, want 01 00", dutOv.r_state, dutNo.r_state);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] pattern = 7'b1011011;
        logic [6:0] wantOv  = 7'b0001001;
        logic [6:0] wantNo  = 7'b0001000;
        logic oOv, oNo;
        int pulsesOv = 0;
        int pulsesNo = 0;
        applyReset();
        for (int i = 6; i >= 0; i--) begin
            stepBit(pattern[i], oOv, oNo);
            pulsesOv += int'(oOv === 1'b1);
            pulsesNo += int'(oNo === 1'b1);
            checks++;
            if (oOv !== wantOv[i] || oNo !== wantNo[i]) begin
                errors++;
                $display("[TB] FAIL overlap_bit%0d: got ov=%b no=%b, want ov=%b no=%b",
                         7 - i, oOv, oNo, wantOv[i], wantNo[i]);
            end
        end
        checks++;
        if (pulsesOv != 2 || pulsesNo != 1) begin
            errors++;
            $display("[TB] FAIL overlap_count: got ov=%0d no=%0d, want 2 1", pulsesOv, pulsesNo);
        end
    endtask

    task automatic test_near_miss();
        // 111111, 10011, 10100 never match; final 101011 matches on its last bit via S101->S10->S101.
        logic [21:0] pattern = 22'b111111_10011_10100_101011;
        logic [21:0] want    = 22'b000000_00000_00000_000001;
        logic oOv, oNo;
        applyReset();
        for (int i = 21; i >= 0; i--) begin
            stepBit(pattern[i], oOv, oNo);
            checks++;
            if (oOv !== want[i] || oNo !== want[i]) begin
                errors++;
                $display("[TB] FAIL near_miss_bit%0d: got ov=%b no=%b, want %b", 22 - i, oOv, oNo, want[i]);
            end
        end
    endtask

    task automatic test_mealy_comb();
        logic oOv, oNo;
        logic [2:0] toggles = 3'b010;
        applyReset();
        stepBit(1'b1, oOv, oNo);
        stepBit(1'b0, oOv, oNo);
        stepBit(1'b1, oOv, oNo);
        for (int i = 2; i >= 0; i--) begin
            sequence_in = toggles[i];
            #2;
            checks++;
            if (detOv !== toggles[i] || detNo !== toggles[i]) begin
                errors++;
                $display("[TB] FAIL mealy_follow%0d: got ov=%b no=%b, want %b", 2 - i, detOv, detNo, toggles[i]);
            end
        end
        @(posedge clock);
        #1;
        checks++;
        if (dutOv.r_state !== 2'b10) begin
            errors++;
            $display("[TB] FAIL mealy_state: got %b, want 10", dutOv.r_state);
        end
    endtask

    task automatic test_reset_mid_pattern();
        logic oOv, oNo;
        logic [3:0] tail = 4'b1011;
        logic [3:0] want = 4'b0001;
        applyReset();
        stepBit(1'b1, oOv, oNo);
        stepBit(1'b0, oOv, oNo);
        stepBit(1'b1, oOv, oNo);
        reset = 1'b0;
        stepBit(1'b0, oOv, oNo);
        reset = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            stepBit(tail[i], oOv, oNo);
            checks++;
            if (oOv !== want[i] || oNo !== want[i]) begin
                errors++;
                $display("[TB] FAIL reset_mid_bit%0d: got ov=%b no=%b, want %b", 4 - i, oOv, oNo, want[i]);
            end
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        sequence_in = 1'b0;
        @(posedge clock);
        #1;
        test_reset();
        test_single_match();
        test_overlap();
        test_near_miss();
        test_mealy_comb();
        test_reset_mid_pattern();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
